// File: rtl/pkt_sample_tagger_pkg.sv
// Shared definitions for the packet sample tagger: entry layout and the
// constants shared with the per-packet counter.
package pkt_sample_tagger_pkg;

    localparam int PKT_DATA_WIDTH  = 32;
    // The counter is 3 bits wide and wraps 7 -> 0, so one tag in eight is sampled.
    localparam int PKT_COUNT_WIDTH = 3;
    localparam int PKT_FIFO_DEPTH  = 4;
    localparam int PKT_STAT_WIDTH  = 16;
    localparam logic [PKT_COUNT_WIDTH-1:0] PKT_SAMPLE_VALUE = '0;

    typedef struct packed {
        logic [PKT_DATA_WIDTH-1:0]  data;
        logic [PKT_COUNT_WIDTH-1:0] tag;
        logic                       sample;
    } pkt_entry_t;

endpackage

// File: rtl/pkt_sample_tagger_fifo.sv
// Synchronous FIFO with register storage, no fall-through: an entry pushed in
// cycle N is visible at the head in cycle N+1 at the earliest.
module pkt_sample_tagger_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occupancy;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (occupancy == DEPTH_L);
    assign empty    = (occupancy == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({push_ok, pop_ok})
                2'b10:   occupancy <= occupancy + (AW + 1)'(1);
                2'b01:   occupancy <= occupancy - (AW + 1)'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pkt_sample_tagger.sv
// Tags each accepted packet with the counter's post-increment value, flags
// sampled packets, buffers them downstream and counts emitted samples.
module pkt_sample_tagger
    import pkt_sample_tagger_pkg::*;
#(
    parameter int DATA_WIDTH  = PKT_DATA_WIDTH,
    parameter int COUNT_WIDTH = PKT_COUNT_WIDTH,
    parameter int FIFO_DEPTH  = PKT_FIFO_DEPTH,
    parameter logic [COUNT_WIDTH-1:0] SAMPLE_VALUE = PKT_SAMPLE_VALUE,
    parameter int STAT_WIDTH  = PKT_STAT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i__pkt__valid,
    input  logic [DATA_WIDTH-1:0]  i__pkt__data,
    output logic                   o__pkt__ready,
    output logic                   o__inc,
    input  logic [COUNT_WIDTH-1:0] i__count,
    output logic                   o__out__valid,
    output logic [DATA_WIDTH-1:0]  o__out__data,
    output logic [COUNT_WIDTH-1:0] o__out__tag,
    output logic                   o__out__sample,
    input  logic                   i__out__ready,
    output logic [STAT_WIDTH-1:0]  o__sample__count
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  data;
        logic [COUNT_WIDTH-1:0] tag;
        logic                   sample;
    } entry_t;

    entry_t                push_entry;
    entry_t                head;
    logic                  full;
    logic                  empty;
    logic                  accept;
    logic                  emit;
    logic [STAT_WIDTH-1:0] sample_count_q;

    // Handshakes: a transfer happens in any cycle where valid and ready are
    // both high at the rising edge. Ready depends only on FIFO occupancy and
    // reset, never on i__count, which avoids a loop through the counter.
    assign o__pkt__ready = !full && !rst;
    assign accept        = i__pkt__valid && o__pkt__ready;
    assign o__inc        = accept;

    // i__count already reflects this cycle's increment, so it is the post-increment tag.
    assign push_entry = '{data: i__pkt__data, tag: i__count, sample: (i__count == SAMPLE_VALUE)};

    pkt_sample_tagger_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (push_entry),
        .pop       (emit),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    assign o__out__valid  = !empty;
    assign emit           = o__out__valid && i__out__ready;
    assign o__out__data   = head.data;
    assign o__out__tag    = empty ? '0 : head.tag;
    assign o__out__sample = !empty && head.sample;

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_count_q <= '0;
        end else if (emit && head.sample && (sample_count_q != '1)) begin
            sample_count_q <= sample_count_q + STAT_WIDTH'(1);
        end
    end

    assign o__sample__count = sample_count_q;

endmodule

// File: tb/tb_pkt_sample_tagger.sv
// Randomized and directed bench for pkt_sample_tagger against a queue-based
// reference model and a behavioural model of the external 3-bit counter.
module tb_pkt_sample_tagger;
    import pkt_sample_tagger_pkg::*;

    localparam int DW      = PKT_DATA_WIDTH;
    localparam int CW      = PKT_COUNT_WIDTH;
    localparam int DEPTH   = PKT_FIFO_DEPTH;
    localparam int SW      = PKT_STAT_WIDTH;
    localparam int ENTRY_W = $bits(pkt_entry_t);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pkt_valid = 1'b0;
    logic [DW-1:0] pkt_data = '0;
    logic          pkt_ready;
    logic          inc;
    logic [CW-1:0] count;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_tag;
    logic          out_sample;
    logic          out_ready = 1'b0;
    logic [SW-1:0] sample_count;

    // clock / counter model
    always #5 clk = ~clk;

    logic [CW-1:0] cnt = '0;
    always @(posedge clk) if (inc) cnt <= cnt + 3'd1;
    assign count = cnt + {2'b00, inc};

    pkt_sample_tagger dut (
        .clk              (clk),
        .rst              (rst),
        .i__pkt__valid    (pkt_valid),
        .i__pkt__data     (pkt_data),
        .o__pkt__ready    (pkt_ready),
        .o__inc           (inc),
        .i__count         (count),
        .o__out__valid    (out_valid),
        .o__out__data     (out_data),
        .o__out__tag      (out_tag),
        .o__out__sample   (out_sample),
        .i__out__ready    (out_ready),
        .o__sample__count (sample_count)
    );

    // scoreboard state
    logic [ENTRY_W-1:0] exp_q[$];
    pkt_entry_t         obs_log[$];
    logic [SW-1:0]      model_stat = '0;
    int                 checks = 0;
    int                 failures = 0;
    int                 inc_seen = 0;
    logic               obs_ready, obs_inc, obs_valid;
    logic [DW-1:0]      obs_data;
    logic [SW-1:0]      obs_stat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // driver: one cycle, inputs at negedge, outputs checked 1ns later, model advanced
    task automatic step(input logic r, input logic v, input logic [DW-1:0] d,
                        input logic ordy, output logic acc);
        logic       exp_ready, exp_valid;
        logic [CW-1:0] post;
        pkt_entry_t head, ne;
        @(negedge clk);
        rst = r; pkt_valid = v; pkt_data = d; out_ready = ordy;
        #1;
        exp_ready = !r && (exp_q.size() < DEPTH);
        exp_valid = (exp_q.size() != 0);
        acc       = v && exp_ready;
        check("pkt_ready", pkt_ready, exp_ready);
        check("inc", inc, acc);
        check("out_valid", out_valid, exp_valid);
        if (exp_valid) begin
            head = pkt_entry_t'(exp_q[0]);
            check("out_data", out_data, head.data);
            check("out_tag", out_tag, head.tag);
            check("out_sample", out_sample, head.sample);
        end else begin
            check("empty_tag", out_tag, 0);
            check("empty_sample", out_sample, 0);
        end
        check("sample_count", sample_count, model_stat);
        obs_ready = pkt_ready; obs_inc = inc; obs_valid = out_valid;
        obs_data = out_data; obs_stat = sample_count;
        if (inc) inc_seen++;
        if (r) begin
            exp_q.delete();
            model_stat = '0;
        end else begin
            if (exp_valid && ordy) begin
                head = pkt_entry_t'(exp_q[0]);
                if (head.sample && model_stat != '1) model_stat++;
                obs_log.push_back('{data: out_data, tag: out_tag, sample: out_sample});
                void'(exp_q.pop_front());
            end
            if (acc) begin
                post = cnt + 3'd1;
                ne = '{data: d, tag: post, sample: (post == PKT_SAMPLE_VALUE)};
                exp_q.push_back(ne);
            end
        end
    endtask

    task automatic drain();
        logic a;
        repeat (DEPTH + 2) step(1'b0, 1'b0, '0, 1'b1, a);
        check("drained", exp_q.size(), 0);
    endtask

    logic [DW-1:0] sent_q[$];

    initial begin
        logic          a;
        logic [DW-1:0] d;
        int            n, acc_n, inc0, cyc;
        logic [SW-1:0] stat0;
        logic [CW-1:0] exp_tags [8];
        exp_tags = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

        // reset
        @(posedge clk);
        step(1'b1, 1'b0, '0, 1'b0, a);
        check("rst_stat", obs_stat, 0);

        // 8 back-to-back packets, downstream always ready
        obs_log.delete();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, DW'(32'h10 + i), 1'b1, a);
        drain();
        check("p1_emitted", obs_log.size(), 8);
        for (int i = 0; i < 8 && i < obs_log.size(); i++) begin
            check("p1_tag", obs_log[i].tag, exp_tags[i]);
            check("p1_data", obs_log[i].data, 32'h10 + i);
            check("p1_sample", obs_log[i].sample, (i == 7));
        end
        check("p1_stat", sample_count, 1);

        // downstream stalled: 6 offered, 4 fit
        inc0 = inc_seen; acc_n = 0; d = 32'h100;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, d, 1'b0, a);
            if (a) begin acc_n++; d++; end
        end
        check("p2_accepted", acc_n, 4);
        check("p2_inc_pulses", inc_seen - inc0, 4);
        check("p2_ready_low", obs_ready, 0);
        check("p2_head_data", obs_data, 32'h100);

        // full: one pop with no same-cycle push, then ready returns
        step(1'b0, 1'b1, d, 1'b1, a);
        check("p3_no_push_full", obs_inc, 0);
        step(1'b0, 1'b1, d, 1'b0, a);
        check("p3_ready_back", obs_ready, 1);
        check("p3_accept", obs_inc, 1);
        drain();

        // random stream of 64 packets
        obs_log.delete(); sent_q.delete();
        inc0 = inc_seen; stat0 = model_stat; n = 0; cyc = 0;
        d = $urandom;
        while (n < 64 && cyc < 2000) begin
            step(1'b0, ($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 1)), a);
            if (a) begin sent_q.push_back(d); n++; d = $urandom; end
            cyc++;
        end
        check("p4_budget", n, 64);
        drain();
        check("p4_inc_count", inc_seen - inc0, 64);
        check("p4_stat", sample_count, stat0 + 16'd8);
        check("p4_emitted", obs_log.size(), sent_q.size());
        for (int i = 0; i < sent_q.size() && i < obs_log.size(); i++)
            check("p4_order", obs_log[i].data, sent_q[i]);

        // statistic saturation
        @(negedge clk);
        pkt_valid = 1'b0;
        force dut.sample_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.sample_count_q;
        model_stat = 16'hFFFE;
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, DW'($urandom), 1'b1, a);
        drain();
        check("p5_saturated", sample_count, 16'hFFFF);

        // reset with 3 entries queued
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, DW'(32'h200 + i), 1'b0, a);
        step(1'b1, 1'b0, '0, 1'b0, a);
        step(1'b0, 1'b0, '0, 1'b0, a);
        check("p6_flushed_valid", obs_valid, 0);
        check("p6_flushed_stat", obs_stat, 0);
        step(1'b0, 1'b1, 32'hABCD, 1'b1, a);
        step(1'b0, 1'b0, '0, 1'b1, a);
        check("p6_latency_valid", obs_valid, 1);
        check("p6_latency_data", obs_data, 32'hABCD);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
